// File: rtl/brisc_pkg.sv
// Shared brisc core definitions: ISA widths, boot/trap vectors and fetch-stage types.
package brisc_pkg;

  localparam int ILEN           = 32;
  localparam int CACHE_LINE_LEN = 512;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] PC_BOOT   = 32'h0000_1000;
  localparam logic [31:0] PC_EXCEPT = 32'h0000_2000;

  localparam int LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN / 8);
  localparam int WORDS_PER_LINE   = CACHE_LINE_LEN / ILEN;

  typedef enum logic [1:0] {
    FETCH_RUN  = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_line_buffer.sv
// Single-line instruction buffer: line/tag/valid storage, tag compare and word select.
module fetch_line_buffer #(
  parameter int ILEN           = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int CACHE_LINE_LEN = 512
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              fill_en,
  input  logic [ADDRESS_BITS-$clog2(CACHE_LINE_LEN/8)-1:0]  fill_tag,
  input  logic [CACHE_LINE_LEN-1:0]                         fill_data,
  input  logic [ADDRESS_BITS-$clog2(CACHE_LINE_LEN/8)-1:0]  lookup_tag,
  input  logic [$clog2(CACHE_LINE_LEN/ILEN)-1:0]            word_sel,
  output logic                                              hit,
  output logic [ILEN-1:0]                                   word
);

  localparam int OFF_W = $clog2(CACHE_LINE_LEN / 8);
  localparam int TAG_W = ADDRESS_BITS - OFF_W;

  logic [CACHE_LINE_LEN-1:0] line_q;
  logic [TAG_W-1:0]          tag_q;
  logic                      valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
    end
  end

  // Line contents are only meaningful once valid_q is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_q <= fill_data;
      tag_q  <= fill_tag;
    end
  end

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign word = line_q[word_sel*ILEN +: ILEN];

endmodule

// File: rtl/fetch_stage.sv
// brisc instruction fetch: PC, line refill FSM and registered F/D interface to decode.
module fetch_stage
  import brisc_pkg::*;
#(
  parameter int                      ILEN           = brisc_pkg::ILEN,
  parameter int                      ADDRESS_BITS   = 32,
  parameter int                      CACHE_LINE_LEN = 512,
  parameter logic [ADDRESS_BITS-1:0] PC_RESET       = PC_BOOT,
  parameter logic [ADDRESS_BITS-1:0] PC_TRAP        = PC_EXCEPT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall_i,
  input  logic                      branch_taken_i,
  input  logic [ADDRESS_BITS-1:0]   branch_target_i,
  input  logic                      except_i,
  output logic                      mem_req_o,
  output logic [ADDRESS_BITS-1:0]   mem_addr_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_resp_valid_i,
  input  logic [CACHE_LINE_LEN-1:0] mem_resp_data_i,
  output logic [ILEN-1:0]           instr_o,
  output logic [ADDRESS_BITS-1:0]   pc_o,
  output logic                      valid_o
);

  localparam int OFF_W = $clog2(CACHE_LINE_LEN / 8);
  localparam int SEL_W = $clog2(CACHE_LINE_LEN / ILEN);
  localparam int BYTE_W = $clog2(ILEN / 8);
  localparam logic [ADDRESS_BITS-1:0] LINE_MASK = ~((ADDRESS_BITS'(1) << OFF_W) - ADDRESS_BITS'(1));
  localparam logic [ADDRESS_BITS-1:0] WORD_MASK = ~((ADDRESS_BITS'(1) << BYTE_W) - ADDRESS_BITS'(1));

  fetch_state_e            state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q;
  logic [ADDRESS_BITS-1:0] req_addr_q;
  logic [ADDRESS_BITS-1:0] redir_raw;
  logic [ADDRESS_BITS-1:0] redir_target;
  logic                    redir;
  logic                    fill_en;
  logic                    hit;
  logic [ILEN-1:0]         hit_word;

  logic [ILEN-1:0]         instr_p1;
  logic [ADDRESS_BITS-1:0] pc_p1;
  logic                    vld_p1;

  assign redir        = except_i | branch_taken_i;
  assign redir_raw    = except_i ? PC_TRAP : branch_target_i;
  assign redir_target = redir_raw & WORD_MASK;
  assign fill_en      = (state_q == FETCH_WAIT) && mem_resp_valid_i;

  fetch_line_buffer #(
    .ILEN           (ILEN),
    .ADDRESS_BITS   (ADDRESS_BITS),
    .CACHE_LINE_LEN (CACHE_LINE_LEN)
  ) u_line_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill_en    (fill_en),
    .fill_tag   (req_addr_q[ADDRESS_BITS-1:OFF_W]),
    .fill_data  (mem_resp_data_i),
    .lookup_tag (pc_q[ADDRESS_BITS-1:OFF_W]),
    .word_sel   (pc_q[OFF_W-1 -: SEL_W]),
    .hit        (hit),
    .word       (hit_word)
  );

  // A redirect in RUN moves the PC instead of refilling the stale one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_RUN:  if (!redir && !hit)   state_d = FETCH_REQ;
      FETCH_REQ:  if (mem_ready_i)      state_d = FETCH_WAIT;
      FETCH_WAIT: if (mem_resp_valid_i) state_d = FETCH_RUN;
      default:                          state_d = FETCH_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_RUN;
      req_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH_RUN && state_d == FETCH_REQ) begin
        req_addr_q <= pc_q & LINE_MASK;
      end
    end
  end

  assign mem_req_o  = (state_q == FETCH_REQ);
  assign mem_addr_o = req_addr_q;

  // ---- F/D register boundary (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_RESET;
      instr_p1 <= NOP;
      pc_p1    <= PC_RESET;
      vld_p1   <= 1'b0;
    end else if (redir) begin
      pc_q     <= redir_target;
      instr_p1 <= NOP;
      pc_p1    <= redir_target;
      vld_p1   <= 1'b0;
    end else if (!stall_i) begin
      if (state_q == FETCH_RUN && hit) begin
        pc_q     <= pc_q + ADDRESS_BITS'(4);
        instr_p1 <= hit_word;
        pc_p1    <= pc_q;
        vld_p1   <= 1'b1;
      end else begin
        instr_p1 <= NOP;
        pc_p1    <= pc_q;
        vld_p1   <= 1'b0;
      end
    end
  end

  assign instr_o = instr_p1;
  assign pc_o    = pc_p1;
  assign valid_o = vld_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: refill handshake, hit streaming, stall, redirects and reset.
module tb_fetch_stage;
  import brisc_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall_i;
  logic         branch_taken_i;
  logic [31:0]  branch_target_i;
  logic         except_i;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ready_i;
  logic         mem_resp_valid_i;
  logic [511:0] mem_resp_data_i;
  logic [31:0]  instr_o;
  logic [31:0]  pc_o;
  logic         valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .branch_taken_i   (branch_taken_i),
    .branch_target_i  (branch_target_i),
    .except_i         (except_i),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_ready_i      (mem_ready_i),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .instr_o          (instr_o),
    .pc_o             (pc_o),
    .valid_o          (valid_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_line(input logic [31:0] base);
    for (int i = 0; i < 16; i++) mem_resp_data_i[32*i +: 32] = base + 32'(i);
  endtask

  task automatic chk_fd(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                        input logic v);
    chk({tag, "_instr"}, instr_o, ins);
    chk({tag, "_pc"}, pc_o, pc);
    chk({tag, "_valid"}, {31'b0, valid_o}, {31'b0, v});
  endtask

  // Wait (bounded) for a request, accept it, then return the line; leaves the FSM in RUN.
  task automatic do_refill(input logic [31:0] exp_addr, input logic [31:0] base);
    int n = 0;
    while (!mem_req_o && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {31'b0, mem_req_o}, 32'd1);
    chk("req_addr", mem_addr_o, exp_addr);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    chk("wait_req_low", {31'b0, mem_req_o}, 32'd0);
    load_line(base);
    mem_resp_valid_i = 1'b1;
    tick();
    mem_resp_valid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
    except_i = 1'b0; mem_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    tick(); tick();
    chk_fd("reset", 32'h0000_0013, 32'h0000_1000, 1'b0);
    chk("reset_req", {31'b0, mem_req_o}, 32'd0);
    chk("reset_addr", mem_addr_o, 32'd0);

    rst_n = 1'b1;
    tick();
    chk("boot_req", {31'b0, mem_req_o}, 32'd1);
    chk("boot_addr", mem_addr_o, 32'h0000_1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", {31'b0, mem_req_o}, 32'd1);
      chk("hold_addr", mem_addr_o, 32'h0000_1000);
    end
    do_refill(32'h0000_1000, 32'h100);

    for (int i = 0; i < 16; i++) begin
      tick();
      chk_fd("stream", 32'h100 + 32'(i), 32'h1000 + 32'(4*i), 1'b1);
    end
    tick();
    chk_fd("miss_1040", 32'h13, 32'h1040, 1'b0);
    chk("miss_req", {31'b0, mem_req_o}, 32'd1);
    chk("miss_addr", mem_addr_o, 32'h0000_1040);

    // Redirect while the request is pending: request stays up with the old address.
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_1000;
    tick();
    branch_taken_i = 1'b0;
    chk_fd("br_in_req", 32'h13, 32'h1000, 1'b0);
    chk("br_in_req_req", {31'b0, mem_req_o}, 32'd1);
    chk("br_in_req_addr", mem_addr_o, 32'h0000_1040);
    do_refill(32'h0000_1040, 32'h200);
    tick();
    chk("after_1040_valid", {31'b0, valid_o}, 32'd0);
    do_refill(32'h0000_1000, 32'h100);

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_fd("pre_stall", 32'h100 + 32'(i), 32'h1000 + 32'(4*i), 1'b1);
    end
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_fd("stall", 32'h102, 32'h1008, 1'b1);
      chk("stall_req", {31'b0, mem_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    tick();
    chk_fd("post_stall", 32'h103, 32'h100C, 1'b1);

    branch_taken_i = 1'b1; branch_target_i = 32'h0000_1023;
    tick();
    branch_taken_i = 1'b0;
    chk_fd("br_hit", 32'h13, 32'h1020, 1'b0);
    chk("br_hit_req", {31'b0, mem_req_o}, 32'd0);
    tick();
    chk_fd("br_target", 32'h108, 32'h1020, 1'b1);
    chk("br_target_req", {31'b0, mem_req_o}, 32'd0);

    except_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h0000_1100; stall_i = 1'b1;
    tick();
    except_i = 1'b0; branch_taken_i = 1'b0; stall_i = 1'b0;
    chk_fd("trap", 32'h13, 32'h2000, 1'b0);
    tick();
    chk("trap_req", {31'b0, mem_req_o}, 32'd1);
    chk("trap_addr", mem_addr_o, 32'h0000_2000);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    chk("trap_wait", {31'b0, mem_req_o}, 32'd0);

    // Asynchronous reset while waiting on the trap-line response.
    rst_n = 1'b0;
    #1;
    chk_fd("rst_wait", 32'h13, 32'h1000, 1'b0);
    chk("rst_wait_req", {31'b0, mem_req_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    load_line(32'h300);
    mem_resp_valid_i = 1'b1;
    tick();
    mem_resp_valid_i = 1'b0;
    chk("stray_req", {31'b0, mem_req_o}, 32'd1);
    chk("stray_addr", mem_addr_o, 32'h0000_1000);
    chk("stray_valid", {31'b0, valid_o}, 32'd0);
    mem_resp_valid_i = 1'b1;
    tick();
    mem_resp_valid_i = 1'b0;
    chk("resp_in_req_ignored", {31'b0, mem_req_o}, 32'd1);

    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_2040;
    tick();
    branch_taken_i = 1'b0;
    chk_fd("br_in_wait", 32'h13, 32'h2040, 1'b0);
    chk("br_in_wait_req", {31'b0, mem_req_o}, 32'd0);
    load_line(32'h100);
    mem_resp_valid_i = 1'b1;
    tick();
    mem_resp_valid_i = 1'b0;
    tick();
    chk("refetch_req", {31'b0, mem_req_o}, 32'd1);
    chk("refetch_addr", mem_addr_o, 32'h0000_2040);
    chk("refetch_valid", {31'b0, valid_o}, 32'd0);
    do_refill(32'h0000_2040, 32'h400);
    tick();
    chk_fd("line_2040_w0", 32'h400, 32'h2040, 1'b1);
    tick();
    chk_fd("line_2040_w1", 32'h401, 32'h2044, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the brisc core. It holds the PC and a single-line instruction buffer of one CACHE_LINE_LEN line (16 instructions), and refills that buffer from memory over a valid/ready request with a single-beat response. It delivers instruction/PC pairs to decode through a registered F/D interface. It accepts branch and exception redirects from downstream.

Parameters:
ILEN, 32, instruction width (brisc_pkg::ILEN)
ADDRESS_BITS, 32, PC/address width
CACHE_LINE_LEN, 512, refill line width in bits; must be a power of two and a multiple of ILEN
PC_RESET, brisc_pkg::PC_BOOT (0x00001000), PC after reset
PC_TRAP, brisc_pkg::PC_EXCEPT (0x00002000), exception redirect target

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
stall_i  in  1  decode cannot accept; hold F/D register and PC
branch_taken_i  in  1  redirect to branch_target_i
branch_target_i  in  ADDRESS_BITS  branch target; bits [1:0] ignored
except_i  in  1  redirect to PC_TRAP
mem_req_o  out  1  line refill request valid
mem_addr_o  out  ADDRESS_BITS  line-aligned refill address
mem_ready_i  in  1  memory accepts request
mem_resp_valid_i  in  1  refill data valid (one beat)
mem_resp_data_i  in  CACHE_LINE_LEN  refill line; word i at bits [32i+31:32i]
instr_o  out  ILEN  F/D instruction
pc_o  out  ADDRESS_BITS  F/D PC
valid_o  out  1  F/D contents are a real instruction

Behaviour:
- Reset (async, rst_n=0): pc=PC_RESET; buffer valid=0; FSM=RUN; instr_o=NOP (0x00000013); pc_o=PC_RESET; valid_o=0; mem_req_o=0; mem_addr_o=0.
- Hit: buf_valid && buf_tag==pc[31:6]. Word select is pc[5:2]. Offset width is log2(CACHE_LINE_LEN/8).
- RUN, no redirect, !stall_i, hit: next edge F/D <= {line word, pc, valid 1}; pc <= pc+4. PC wraps modulo 2^32. Hit-to-output latency is 1 cycle.
- RUN, miss: F/D <= {NOP, pc, 0}; FSM -> REQ next edge; latch req_addr={pc[31:6],6'b0}.
- REQ: mem_req_o=1; mem_addr_o=req_addr. Both are held stable until mem_ready_i. On the accept edge, FSM -> WAIT.
- WAIT: mem_req_o=0. On mem_resp_valid_i: line/tag/valid <= data/req_addr tag/1; FSM -> RUN. The hit is checked on the following cycle.
- mem_resp_valid_i outside WAIT is ignored.
- Stall: when stall_i=1 with no redirect, the F/D register and pc hold. The FSM still progresses through REQ and WAIT, so a refill completes under stall.
- Redirect priority: except_i > branch_taken_i > stall_i. A redirect overrides stall.
  - pc <= target with bits [1:0] forced to 0.
  - F/D <= {NOP, target, 0}.
- Redirect in RUN: takes effect next cycle. If the target is in the buffered line, there is no refill.
- Redirect in REQ or WAIT: the outstanding transaction is not cancelled. The request stays asserted until accepted, and the response still fills the buffer with req_addr's line. The FSM then returns to RUN and the new pc is checked; a miss starts a new refill.
- Redirect on the same edge as mem_resp_valid_i: the fill and the pc update both occur.
- Only one outstanding request at a time.
- Reset asserted mid-REQ/WAIT: everything returns to reset values immediately. A later stray response is ignored because the FSM is in RUN.

Decomposition:
- Add to brisc_pkg:
  - fetch_state_e {FETCH_RUN, FETCH_REQ, FETCH_WAIT}
  - LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN/8) = 6
  - WORDS_PER_LINE = CACHE_LINE_LEN/ILEN = 16
  - Reuse the existing NOP, PC_BOOT and PC_EXCEPT.
- Sub-module fetch_line_buffer: line/tag/valid storage, hit compare and word mux.
- fetch_stage keeps the PC, FSM and F/D register.

Test Plan:
- Reset release -> pc_o=0x1000, valid_o=0. Next cycle mem_req_o=1 with mem_addr_o=0x1000. Hold mem_ready_i=0 for 3 cycles: addr stays stable.
- Refill 0x1000 with word i=0x100+i -> 16 consecutive outputs pc 0x1000..0x103C with instr 0x100..0x10F, valid=1. Then a miss requests 0x1040.
- stall_i=1 for 4 cycles after pc_o=0x1008 -> instr_o/pc_o/valid_o unchanged; no request issued. After release, 0x100C follows.
- branch_taken_i with target 0x1023 while the 0x1000 line is buffered -> next pc_o=0x1020 with valid_o=0. Then instr 0x108 at pc 0x1020 with no mem_req_o.
- Redirect to 0x2040 during WAIT for 0x1000 -> fill completes, then a request to 0x2040, then valid output at pc 0x2040.
- except_i and branch_taken_i asserted together, plus stall_i -> pc <= 0x2000 (PC_TRAP). rst_n pulsed during WAIT -> pc_o=0x1000, mem_req_o=0, and a late mem_resp_valid_i does not set the buffer valid.
